// File: rtl/bf_io_uart.sv
// bf_io_uart: buffered 8N1 UART on the bfcpu io_* handshake.
// TX/RX FIFOs, LED mirror of last write, sticky RX overrun flag.
module bf_io_uart #(
  parameter int   CLK_DIV   = 104,
  parameter int   TX_DEPTH  = 16,
  parameter int   RX_DEPTH  = 16,
  parameter int   LED_W     = 3,
  parameter logic DIR_WRITE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_req,
  input  logic             io_dir,
  input  logic [7:0]       io_wdata,
  output logic             io_ack,
  output logic [7:0]       io_rdata,
  output logic             uart_tx,
  input  logic             uart_rx,
  output logic [LED_W-1:0] led_n,
  output logic             rx_overrun
);

  localparam int CW  = $clog2(CLK_DIV + 1);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_FULL = CW'(CLK_DIV);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_e;

  logic             ack_q;
  logic [7:0]       rdata_q;
  logic [LED_W-1:0] led_q;

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_rp_q;
  logic [TAW:0]   tx_cnt_q;
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_rp_q;
  logic [RAW:0]   rx_cnt_q;

  state_e      tx_st_q;
  logic [CW-1:0] tx_tmr_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_sh_q;
  logic        tx_q;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  state_e      rx_st_q;
  logic [CW-1:0] rx_tmr_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        ovr_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic wr_acc, rd_acc, tx_pop, rx_push;
  logic tx_bit_end, rx_fall, rx_stop_smp;

  assign tx_full  = tx_cnt_q == (TAW+1)'(TX_DEPTH);
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == (RAW+1)'(RX_DEPTH);
  assign rx_empty = rx_cnt_q == '0;

  assign wr_acc = io_req && !ack_q &&
                  (io_dir == DIR_WRITE) && !tx_full;
  assign rd_acc = io_req && !ack_q &&
                  (io_dir != DIR_WRITE) && !rx_empty;

  assign tx_bit_end = tx_tmr_q == BIT_LAST;
  assign tx_pop = !tx_empty &&
                  ((tx_st_q == IDLE) ||
                   (tx_st_q == STOP && tx_bit_end));

  assign rx_fall     = rx_prev_q && !rx_s2_q;
  assign rx_stop_smp = (rx_st_q == STOP) && (rx_tmr_q == BIT_FULL);
  assign rx_push     = rx_stop_smp && rx_s2_q && !rx_full;

  assign io_ack     = ack_q;
  assign io_rdata   = rdata_q;
  assign uart_tx    = tx_q;
  assign led_n      = led_q;
  assign rx_overrun = ovr_q;

  // CPU side: one-cycle ack, LED mirror, read data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      led_q   <= '1;
    end else begin
      ack_q <= wr_acc || rd_acc;
      if (wr_acc) led_q   <= ~io_wdata[LED_W-1:0];
      if (rd_acc) rdata_q <= rx_mem[rx_rp_q];
    end
  end

  // FIFO storage, no reset needed on the data
  always_ff @(posedge clk) begin
    if (wr_acc)  tx_mem[tx_wp_q] <= io_wdata;
    if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (wr_acc) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop) tx_rp_q <= tx_rp_q + 1'b1;
      if (wr_acc && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!wr_acc && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rd_acc)  rx_rp_q <= rx_rp_q + 1'b1;
      if (rx_push && !rd_acc)      rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_push && rd_acc) rx_cnt_q <= rx_cnt_q - 1'b1;
    end
  end

  // TX serialiser; STOP chains straight into START when data waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q  <= IDLE;
      tx_tmr_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      unique case (tx_st_q)
        IDLE: if (!tx_empty) begin
          tx_sh_q  <= tx_mem[tx_rp_q];
          tx_q     <= 1'b0;
          tx_tmr_q <= '0;
          tx_st_q  <= START;
        end
        START: if (tx_bit_end) begin
          tx_tmr_q <= '0;
          tx_bit_q <= '0;
          tx_q     <= tx_sh_q[0];
          tx_st_q  <= DATA;
        end else tx_tmr_q <= tx_tmr_q + 1'b1;
        DATA: if (tx_bit_end) begin
          tx_tmr_q <= '0;
          if (tx_bit_q == 3'd7) begin
            tx_q    <= 1'b1;
            tx_st_q <= STOP;
          end else begin
            tx_bit_q <= tx_bit_q + 1'b1;
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            tx_q     <= tx_sh_q[1];
          end
        end else tx_tmr_q <= tx_tmr_q + 1'b1;
        STOP: if (tx_bit_end) begin
          tx_tmr_q <= '0;
          if (!tx_empty) begin
            tx_sh_q <= tx_mem[tx_rp_q];
            tx_q    <= 1'b0;
            tx_st_q <= START;
          end else tx_st_q <= IDLE;
        end else tx_tmr_q <= tx_tmr_q + 1'b1;
      endcase
    end
  end

  // RX synchroniser plus falling-edge history, all reset high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX deserialiser; timer starts at 1 so samples land mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q  <= IDLE;
      rx_tmr_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      unique case (rx_st_q)
        IDLE: if (rx_fall) begin
          rx_tmr_q <= CW'(1);
          rx_st_q  <= START;
        end
        START: if (rx_tmr_q == BIT_HALF) begin
          rx_tmr_q <= CW'(1);
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? IDLE : DATA;
        end else rx_tmr_q <= rx_tmr_q + 1'b1;
        DATA: if (rx_tmr_q == BIT_FULL) begin
          rx_tmr_q <= CW'(1);
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_q <= STOP;
          else rx_bit_q <= rx_bit_q + 1'b1;
        end else rx_tmr_q <= rx_tmr_q + 1'b1;
        STOP: if (rx_stop_smp) begin
          rx_st_q <= IDLE;
          if (rx_s2_q && rx_full) ovr_q <= 1'b1;
        end else rx_tmr_q <= rx_tmr_q + 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_io_uart.sv
// tb_bf_io_uart: scoreboard bench for bf_io_uart.
// Drivers push expectations; monitors pop and compare.
module tb_bf_io_uart;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_req = 1'b0;
  logic       io_dir = 1'b0;
  logic [7:0] io_wdata = '0;
  logic       io_ack;
  logic [7:0] io_rdata;
  logic       uart_tx;
  logic       uart_rx = 1'b1;
  logic [2:0] led_n;
  logic       rx_overrun;

  always #5 clk = ~clk;

  bf_io_uart #(
    .CLK_DIV(4), .TX_DEPTH(4), .RX_DEPTH(2),
    .LED_W(3), .DIR_WRITE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .io_req(io_req), .io_dir(io_dir),
    .io_wdata(io_wdata), .io_ack(io_ack),
    .io_rdata(io_rdata), .uart_tx(uart_tx),
    .uart_rx(uart_rx), .led_n(led_n),
    .rx_overrun(rx_overrun)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [8:0] ack_exp[$];
  logic [8:0] tx_exp[$];
  bit tx_mon_off = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // ack monitor: every ack must match the oldest expectation
  logic       am_last = 1'b0;
  logic [8:0] am_e;
  initial begin
    forever begin
      @(negedge clk);
      if (io_ack === 1'b1) begin
        chk("ack_single", 64'(am_last), 64'(0));
        if (ack_exp.size() == 0) begin
          chk("unexpected_ack", 64'(ack_exp.size()), 64'(1));
        end else begin
          am_e = ack_exp.pop_front();
          if (am_e[8])
            chk("rd_data", 64'(io_rdata), 64'(am_e[7:0]));
          else
            chk("wr_led", 64'(led_n), 64'(am_e[2:0]));
        end
      end
      am_last = io_ack;
    end
  end

  // TX monitor: decode 8N1 frames at mid-bit
  int         tm_s;
  int         tm_last = -1000;
  logic [7:0] tm_b;
  logic       tm_p = 1'b1;
  logic       tm_st, tm_sp;
  logic [8:0] tm_e;
  initial begin
    forever begin
      @(negedge clk);
      if (tm_p && !uart_tx && !tx_mon_off && rst_n) begin
        tm_s = cyc;
        repeat (2) @(negedge clk);
        tm_st = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          tm_b[i] = uart_tx;
        end
        repeat (4) @(negedge clk);
        tm_sp = uart_tx;
        if (tx_exp.size() == 0) begin
          chk("tx_unexpected", 64'(tx_exp.size()), 64'(1));
        end else begin
          tm_e = tx_exp.pop_front();
          chk("tx_byte", 64'(tm_b), 64'(tm_e[7:0]));
          chk("tx_frame", 64'({tm_st, tm_sp}), 64'(2'b01));
          if (tm_e[8])
            chk("tx_no_gap", 64'(tm_s - tm_last), 64'(40));
        end
        tm_last = tm_s;
      end
      tm_p = uart_tx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic io_xfer(input logic dir, input logic [7:0] d,
                         input int bound,
                         output bit got, output int lat);
    io_req = 1'b1;
    io_dir = dir;
    io_wdata = d;
    got = 1'b0;
    lat = 0;
    while (!got && lat < bound) begin
      @(negedge clk);
      lat++;
      if (io_ack === 1'b1) got = 1'b1;
    end
    io_req = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d, input int elat);
    bit got;
    int lat;
    logic [2:0] l;
    l = ~d[2:0];
    ack_exp.push_back({1'b0, 5'b0, l});
    io_xfer(1'b1, d, 50, got, lat);
    chk("wr_ack", 64'(got), 64'(1));
    chk("wr_lat", 64'(lat), 64'(elat));
  endtask

  task automatic rd(input logic [7:0] d, input int elat);
    bit got;
    int lat;
    ack_exp.push_back({1'b1, d});
    io_xfer(1'b0, 8'h00, 50, got, lat);
    chk("rd_ack", 64'(got), 64'(1));
    chk("rd_lat", 64'(lat), 64'(elat));
  endtask

  task automatic rd_stall(input string nm);
    bit got;
    int lat;
    io_xfer(1'b0, 8'h00, 60, got, lat);
    chk(nm, 64'(got), 64'(0));
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_drain();
    int t;
    t = 0;
    while (tx_exp.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("tx_drain", 64'(tx_exp.size()), 64'(0));
  endtask

  logic [40:0] wv, wx;
  logic [7:0]  v55;
  logic        allhi;
  bit          sgot;
  int          slat;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_tx", 64'(uart_tx), 64'(1));
    chk("rst_led", 64'(led_n), 64'(3'b111));
    chk("rst_ack", 64'(io_ack), 64'(0));
    chk("rst_ovr", 64'(rx_overrun), 64'(0));
    chk("rst_rdata", 64'(io_rdata), 64'(0));

    // single byte, exact waveform
    v55 = 8'h55;
    tx_exp.push_back({1'b0, v55});
    wr(v55, 1);
    chk("led_55", 64'(led_n), 64'(3'b010));
    for (int j = 0; j < 41; j++) begin
      wv[j] = uart_tx;
      if (j == 0) wx[j] = 1'b1;
      else if ((j - 1) / 4 == 0) wx[j] = 1'b0;
      else if ((j - 1) / 4 == 9) wx[j] = 1'b1;
      else wx[j] = v55[(j - 1) / 4 - 1];
      @(negedge clk);
    end
    chk("tx_wave_55", 64'(wv), 64'(wx));
    tx_drain();

    // back-to-back writes into a 4-deep FIFO
    tx_exp.push_back({1'b0, 8'h41});
    for (int k = 1; k < 5; k++)
      tx_exp.push_back({1'b1, 8'(8'h41 + k)});
    wr(8'h41, 1);
    for (int k = 1; k < 5; k++) wr(8'(8'h41 + k), 2);
    tx_drain();

    // RX frame then read
    send_rx(8'hA3, 1'b1);
    rd(8'hA3, 1);

    // read issued before frame completes
    ack_exp.push_back({1'b1, 8'h5A});
    fork
      send_rx(8'h5A, 1'b1);
      io_xfer(1'b0, 8'h00, 100, sgot, slat);
    join
    chk("rd_early_ack", 64'(sgot), 64'(1));
    chk("rd_early_lat", 64'(slat >= 40 && slat <= 44), 64'(1));

    // overrun with a 2-deep RX FIFO
    chk("ovr_clear", 64'(rx_overrun), 64'(0));
    send_rx(8'h01, 1'b1);
    send_rx(8'h02, 1'b1);
    send_rx(8'h03, 1'b1);
    repeat (8) @(negedge clk);
    chk("ovr_set", 64'(rx_overrun), 64'(1));
    rd(8'h01, 1);
    rd(8'h02, 2);
    rd_stall("rd_empty_stall");
    chk("rdata_hold", 64'(io_rdata), 64'(8'h02));

    // framing error and glitch push nothing
    send_rx(8'h77, 1'b0);
    repeat (8) @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_stall("rd_frame_err_stall");
    chk("ovr_sticky", 64'(rx_overrun), 64'(1));

    // reset in the middle of a TX frame
    tx_mon_off = 1'b1;
    wr(8'h0F, 1);
    wr(8'hF0, 2);
    repeat (20) @(negedge clk);
    chk("tx_mid_low", 64'(uart_tx), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("tx_async_rst", 64'(uart_tx), 64'(1));
    chk("rst2_led", 64'(led_n), 64'(3'b111));
    chk("rst2_ovr", 64'(rx_overrun), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    allhi = 1'b1;
    repeat (60) begin
      @(negedge clk);
      allhi = allhi & uart_tx;
    end
    chk("tx_fifo_cleared", 64'(allhi), 64'(1));
    rd_stall("rd_after_rst_stall");
    chk("rst2_rdata", 64'(io_rdata), 64'(0));
    chk("ack_q_empty", 64'(ack_exp.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
